pll_lock_supervisor: RTL and testbench

Reset and lock sequencer that sits directly around the board PLL. It drives the PLL's `rst` input and consumes its `locked` output, issuing a controlled reset pulse and waiting for lock with a timeout. Lock must then hold stable for a programmable time before the design-wide system reset is released. On loss of lock or a software retune request it re-runs the sequence and counts relock events. The block runs on the free-running 50 MHz board reference clock, never on a PLL output.

---
 rtl/pll_lock_supervisor.sv | 135 +++++++++++++
 tb/tb_pll_lock_supervisor.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pll_lock_supervisor.sv
// rtl/pll_lock_supervisor.sv - PLL reset pulse, lock wait with timeout, stable-lock qualification and system reset release.
module pll_lock_supervisor #(
  parameter int RST_PULSE_CYCLES    = 64,
  parameter int LOCK_STABLE_CYCLES  = 50000,
  parameter int LOCK_TIMEOUT_CYCLES = 500000,
  parameter int CNT_W               = 20,
  parameter int RELOCK_W            = 8
) (
  input  logic                refclk,
  input  logic                rst,
  input  logic                pll_locked,
  input  logic                force_relock,
  output logic                pll_rst,
  output logic                sys_rst,
  output logic                ready,
  output logic                timeout_err,
  output logic [RELOCK_W-1:0] relock_count,
  output logic [1:0]          state_o
);

  typedef enum logic [1:0] {
    PLL_RESET = 2'd0,
    WAIT_LOCK = 2'd1,
    STABILIZE = 2'd2,
    RUN       = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] RST_LOAD     = CNT_W'(RST_PULSE_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LOAD = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] STABLE_LOAD  = CNT_W'(LOCK_STABLE_CYCLES - 1);

  state_t             state;
  state_t             state_nxt;
  logic [CNT_W-1:0]   cnt;
  logic [CNT_W-1:0]   cnt_load;
  logic               cnt_zero;
  logic               lk_meta;
  logic               lk_s;
  logic               set_timeout;
  logic               relock_evt;

  // pll_locked is asynchronous to refclk; only lk_s may reach the FSM.
  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      lk_meta <= 1'b0;
      lk_s    <= 1'b0;
    end else begin
      lk_meta <= pll_locked;
      lk_s    <= lk_meta;
    end
  end

  assign cnt_zero = (cnt == '0);

  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      state <= PLL_RESET;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    set_timeout = 1'b0;
    relock_evt  = 1'b0;
    case (state)
      PLL_RESET: begin
        if (cnt_zero) state_nxt = WAIT_LOCK;
      end
      WAIT_LOCK: begin
        // A lock seen on the final timeout cycle wins over the timeout.
        if (lk_s) begin
          state_nxt = STABILIZE;
        end else if (cnt_zero) begin
          state_nxt   = PLL_RESET;
          set_timeout = 1'b1;
        end
      end
      STABILIZE: begin
        if (!lk_s) begin
          state_nxt = WAIT_LOCK;
        end else if (cnt_zero) begin
          state_nxt = RUN;
        end
      end
      RUN: begin
        if (!lk_s || force_relock) begin
          state_nxt  = PLL_RESET;
          relock_evt = 1'b1;
        end
      end
      default: state_nxt = PLL_RESET;
    endcase
  end

  always_comb begin
    cnt_load = '0;
    case (state_nxt)
      PLL_RESET: cnt_load = RST_LOAD;
      WAIT_LOCK: cnt_load = TIMEOUT_LOAD;
      STABILIZE: cnt_load = STABLE_LOAD;
      default:   cnt_load = '0;
    endcase
  end

  // The single down-counter is reloaded on every state change and parks at zero.
  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      cnt          <= RST_LOAD;
      timeout_err  <= 1'b0;
      relock_count <= '0;
    end else begin
      if (state_nxt != state) begin
        cnt <= cnt_load;
      end else if (!cnt_zero) begin
        cnt <= cnt - CNT_W'(1);
      end
      if (set_timeout) begin
        timeout_err <= 1'b1;
      end
      if (relock_evt && (relock_count != '1)) begin
        relock_count <= relock_count + RELOCK_W'(1);
      end
    end
  end

  always_comb begin
    pll_rst = (state == PLL_RESET);
    sys_rst = (state != RUN);
    ready   = (state == RUN);
    state_o = state;
  end

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// tb/tb_pll_lock_supervisor.sv - directed bench for pll_lock_supervisor with small timing parameters.
module tb_pll_lock_supervisor;

  logic       refclk;
  logic       rst;
  logic       pll_locked;
  logic       force_relock;
  logic       pll_rst;
  logic       sys_rst;
  logic       ready;
  logic       timeout_err;
  logic [7:0] relock_count;
  logic [1:0] state_o;

  int checks;
  int errors;
  int cyc;
  int rel_seen;

  pll_lock_supervisor #(
    .RST_PULSE_CYCLES   (4),
    .LOCK_STABLE_CYCLES (8),
    .LOCK_TIMEOUT_CYCLES(32),
    .CNT_W              (20),
    .RELOCK_W           (8)
  ) dut (
    .refclk      (refclk),
    .rst         (rst),
    .pll_locked  (pll_locked),
    .force_relock(force_relock),
    .pll_rst     (pll_rst),
    .sys_rst     (sys_rst),
    .ready       (ready),
    .timeout_err (timeout_err),
    .relock_count(relock_count),
    .state_o     (state_o)
  );

  initial refclk = 1'b0;
  always #10 refclk = ~refclk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge refclk);
    #1;
    cyc++;
    if (sys_rst === 1'b0) rel_seen++;
  endtask

  task automatic step_to(input int n);
    while (cyc < n) step();
  endtask

  task automatic chk_reset_values(input string tag);
    chk({tag, "_pll_rst"}, {31'd0, pll_rst}, 32'd1);
    chk({tag, "_sys_rst"}, {31'd0, sys_rst}, 32'd1);
    chk({tag, "_ready"}, {31'd0, ready}, 32'd0);
    chk({tag, "_timeout_err"}, {31'd0, timeout_err}, 32'd0);
    chk({tag, "_relock_count"}, {24'd0, relock_count}, 32'd0);
    chk({tag, "_state"}, {30'd0, state_o}, 32'd0);
  endtask

  task automatic relock_pulse();
    int n;
    n = 0;
    while (state_o !== 2'd3 && n < 100) begin
      step();
      n++;
    end
    chk("reach_run", {30'd0, state_o}, 32'd3);
    force_relock = 1'b1;
    step();
    force_relock = 1'b0;
  endtask

  initial begin
    checks       = 0;
    errors       = 0;
    cyc          = 0;
    rel_seen     = 0;
    rst          = 1'b1;
    pll_locked   = 1'b0;
    force_relock = 1'b0;

    #5;
    chk_reset_values("reset");
    @(posedge refclk);
    @(posedge refclk);
    #1;
    rst = 1'b0;
    cyc = 0;

    // Clean start
    chk("start_pll_rst", {31'd0, pll_rst}, 32'd1);
    step_to(3);
    chk("pulse_last_state", {30'd0, state_o}, 32'd0);
    chk("pulse_last_pll_rst", {31'd0, pll_rst}, 32'd1);
    step_to(4);
    chk("pulse_end_pll_rst", {31'd0, pll_rst}, 32'd0);
    chk("wait_lock_entry", {30'd0, state_o}, 32'd1);
    step_to(9);
    pll_locked = 1'b1;
    step_to(11);
    chk("sync_latency_wait", {30'd0, state_o}, 32'd1);
    step_to(12);
    chk("stabilize_entry", {30'd0, state_o}, 32'd2);
    chk("stabilize_sys_rst", {31'd0, sys_rst}, 32'd1);
    step_to(19);
    chk("stable_not_yet", {31'd0, sys_rst}, 32'd1);
    step_to(20);
    chk("run_state", {30'd0, state_o}, 32'd3);
    chk("run_sys_rst", {31'd0, sys_rst}, 32'd0);
    chk("run_ready", {31'd0, ready}, 32'd1);
    chk("run_timeout_err", {31'd0, timeout_err}, 32'd0);
    chk("run_relock_count", {24'd0, relock_count}, 32'd0);

    // Lock loss in RUN, then recovery
    step_to(25);
    pll_locked = 1'b0;
    step_to(27);
    chk("loss_pending_sys_rst", {31'd0, sys_rst}, 32'd0);
    chk("loss_pending_state", {30'd0, state_o}, 32'd3);
    step_to(28);
    chk("loss_state", {30'd0, state_o}, 32'd0);
    chk("loss_pll_rst", {31'd0, pll_rst}, 32'd1);
    chk("loss_sys_rst", {31'd0, sys_rst}, 32'd1);
    chk("loss_relock_count", {24'd0, relock_count}, 32'd1);
    pll_locked = 1'b1;
    step_to(32);
    chk("relock_wait", {30'd0, state_o}, 32'd1);
    step_to(33);
    chk("relock_stabilize", {30'd0, state_o}, 32'd2);
    step_to(40);
    chk("relock_stable_not_yet", {30'd0, state_o}, 32'd2);
    step_to(41);
    chk("relock_run", {30'd0, state_o}, 32'd3);
    chk("relock_ready", {31'd0, ready}, 32'd1);

    // force_relock in RUN, then a one-cycle glitch during STABILIZE
    force_relock = 1'b1;
    step_to(42);
    force_relock = 1'b0;
    chk("force_state", {30'd0, state_o}, 32'd0);
    chk("force_relock_count", {24'd0, relock_count}, 32'd2);
    step_to(46);
    chk("force_wait", {30'd0, state_o}, 32'd1);
    step_to(47);
    chk("force_stabilize", {30'd0, state_o}, 32'd2);
    step_to(51);
    pll_locked = 1'b0;
    step_to(52);
    pll_locked = 1'b1;
    step_to(53);
    chk("glitch_pending", {30'd0, state_o}, 32'd2);
    step_to(54);
    chk("glitch_back_to_wait", {30'd0, state_o}, 32'd1);
    step_to(55);
    chk("glitch_restabilize", {30'd0, state_o}, 32'd2);
    step_to(62);
    chk("glitch_sys_rst_held", {31'd0, sys_rst}, 32'd1);
    step_to(63);
    chk("glitch_run", {30'd0, state_o}, 32'd3);
    chk("glitch_relock_count", {24'd0, relock_count}, 32'd2);

    // Lock loss and force_relock on the same cycle
    pll_locked = 1'b0;
    step_to(65);
    force_relock = 1'b1;
    step_to(66);
    force_relock = 1'b0;
    chk("simul_state", {30'd0, state_o}, 32'd0);
    chk("simul_relock_count", {24'd0, relock_count}, 32'd3);
    step_to(67);
    force_relock = 1'b1;
    step_to(68);
    force_relock = 1'b0;
    chk("force_outside_run_state", {30'd0, state_o}, 32'd0);
    chk("force_outside_run_count", {24'd0, relock_count}, 32'd3);

    // Lock arriving on the last timeout cycle wins
    step_to(70);
    chk("prio_wait", {30'd0, state_o}, 32'd1);
    step_to(99);
    pll_locked = 1'b1;
    step_to(101);
    chk("prio_still_wait", {30'd0, state_o}, 32'd1);
    step_to(102);
    chk("prio_stabilize", {30'd0, state_o}, 32'd2);
    chk("prio_no_timeout", {31'd0, timeout_err}, 32'd0);

    // Asynchronous reset between edges mid-STABILIZE
    step_to(105);
    #4;
    rst = 1'b1;
    #1;
    chk_reset_values("async_rst");
    pll_locked = 1'b0;
    @(posedge refclk);
    @(posedge refclk);
    #1;
    rst = 1'b0;
    cyc = 0;
    rel_seen = 0;
    chk("restart_state", {30'd0, state_o}, 32'd0);
    step_to(3);
    chk("restart_pulse_last", {31'd0, pll_rst}, 32'd1);
    step_to(4);
    chk("restart_pulse_end", {31'd0, pll_rst}, 32'd0);

    // Never locks
    step_to(35);
    chk("nolock_wait_last", {30'd0, state_o}, 32'd1);
    chk("nolock_no_timeout_yet", {31'd0, timeout_err}, 32'd0);
    step_to(36);
    chk("nolock_timeout_state", {30'd0, state_o}, 32'd0);
    chk("nolock_timeout_err", {31'd0, timeout_err}, 32'd1);
    chk("nolock_repulse", {31'd0, pll_rst}, 32'd1);
    step_to(39);
    chk("nolock_repulse_last", {30'd0, state_o}, 32'd0);
    step_to(40);
    chk("nolock_wait_again", {30'd0, state_o}, 32'd1);
    step_to(72);
    chk("nolock_second_timeout", {30'd0, state_o}, 32'd0);
    chk("nolock_timeout_sticky", {31'd0, timeout_err}, 32'd1);
    chk("nolock_never_released", rel_seen, 32'd0);

    // Saturation of the relock counter
    pll_locked = 1'b1;
    relock_pulse();
    chk("sat_first", {24'd0, relock_count}, 32'd1);
    for (int i = 0; i < 254; i++) relock_pulse();
    chk("sat_255", {24'd0, relock_count}, 32'd255);
    for (int i = 0; i < 45; i++) relock_pulse();
    chk("sat_300", {24'd0, relock_count}, 32'd255);
    chk("sat_timeout_sticky", {31'd0, timeout_err}, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
